// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
// Holds the controller state encoding, the row/column-to-hex key map and
// small combinational helpers used by keypad_scan_ctrl.
package keypad_pkg;

  typedef enum logic [2:0] {
    SETTLE,
    SCAN,
    DEB_PRESS,
    PRESSED,
    HELD,
    DEB_RELEASE
  } kp_state_t;

  // KEYMAP[row][col] gives the hex code printed on that key.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Index of the lowest set column bit; the lowest column wins on multi-hot.
  function automatic logic [1:0] lowest_col(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    casez (c)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // True when more than one column line is active.
  function automatic logic is_multi(input logic [3:0] c);
    return (c & (c - 4'd1)) != 4'd0;
  endfunction

  // One-hot row drive pattern for a row index.
  function automatic logic [3:0] row_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: parameterised-width two-flop synchroniser for signals that are
// asynchronous to clk. Output lags the input by two clock edges.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad matrix scanner with press/release debounce,
// hex encoding and a valid/ready hold register toward the display logic.
// Optional build macro: KEYPAD_GHOST_REJECT_EN -- when defined, multi-column
// readings are treated as "no key" while scanning and debouncing a press;
// when undefined, the lowest active column is taken.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       scanning
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [3:0]       cols_s;
  kp_state_t        state;
  logic [1:0]       row_idx;
  logic [1:0]       cand_row;
  logic [3:0]       cand_col;
  logic [3:0]       code_pend;
  logic [CNT_W-1:0] cnt;
  logic             press_ok;

  sync2 #(.W(4)) u_cols_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cols),
    .q     (cols_s)
  );

  // A reading in SCAN that is allowed to start a press debounce.
`ifdef KEYPAD_GHOST_REJECT_EN
  assign press_ok = (cols_s != 4'd0) && !is_multi(cols_s);
`else
  assign press_ok = (cols_s != 4'd0);
`endif

  // Scan/debounce FSM with registered row drive, key hold register and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SETTLE;
      row_idx   <= 2'd0;
      rows      <= 4'b0001;
      cnt       <= '0;
      cand_row  <= 2'd0;
      cand_col  <= 4'd0;
      code_pend <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      scanning  <= 1'b1;
    end else begin
      // Consumer took the key this cycle; a load in PRESSED can only follow.
      if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end

      case (state)
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= SCAN;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        SCAN: begin
          cnt <= '0;
          if (press_ok) begin
            cand_row <= row_idx;
            cand_col <= cols_s;
            scanning <= 1'b0;
            state    <= DEB_PRESS;
          end else begin
            row_idx <= row_idx + 2'd1;
            rows    <= row_onehot(row_idx + 2'd1);
            state   <= SETTLE;
          end
        end

        DEB_PRESS: begin
          // Any change of the column pattern restarts scanning on this row.
          if (cols_s != cand_col) begin
            cnt      <= '0;
            scanning <= 1'b1;
            state    <= SETTLE;
          end else if (cnt == DEB_LAST) begin
            cnt       <= '0;
            code_pend <= KEYMAP[cand_row][lowest_col(cand_col)];
            state     <= PRESSED;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        PRESSED: begin
          // Stall here while the previous key still sits unconsumed.
          cnt <= '0;
          if (!key_valid) begin
            key_code  <= code_pend;
            key_valid <= 1'b1;
            state     <= HELD;
          end
        end

        HELD: begin
          // Only full release matters; other column activity is ignored.
          cnt <= '0;
          if (cols_s == 4'd0) begin
            state <= DEB_RELEASE;
          end
        end

        DEB_RELEASE: begin
          if (cols_s != 4'd0) begin
            cnt   <= '0;
            state <= HELD;
          end else if (cnt == DEB_LAST) begin
            cnt      <= '0;
            row_idx  <= cand_row + 2'd1;
            rows     <= row_onehot(cand_row + 2'd1);
            scanning <= 1'b1;
            state    <= SETTLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          cnt      <= '0;
          scanning <= 1'b1;
          state    <= SETTLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench for keypad_scan_ctrl with a small
// keypad matrix model (a key returns its column only while its row is driven).
module tb_keypad_scan_ctrl;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       key_ready = 1'b1;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       scanning;

  logic       key_on   = 1'b0;
  logic [1:0] key_row  = 2'd0;
  logic [3:0] key_mask = 4'd0;

  int checks = 0;
  int errors = 0;

  logic [3:0] acc[$];

  always #5 clk = ~clk;

  assign cols = (key_on && rows[key_row]) ? key_mask : 4'b0000;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES   (4),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .scanning  (scanning)
  );

  // Record every completed handshake (sampled mid low phase).
  always @(negedge clk) begin
    #1;
    if (!reset && key_valid && key_ready) acc.push_back(key_code);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    acc.delete();
  endtask

  task automatic test_reset();
    // Reset while a key is pending (key_valid=1, not consumed).
    key_row = 2'd1; key_mask = 4'b0100; key_on = 1'b1; key_ready = 1'b0;
    apply_reset();
    step(25);
    checks++;
    if (key_valid !== 1'b1) begin
      errors++; $display("FAIL reset_pre_valid: key_valid=%b expected 1", key_valid);
    end
    @(posedge clk); #3; reset = 1'b1; #1;
    checks++;
    if (rows !== 4'b0001) begin
      errors++; $display("FAIL reset_rows: rows=%b expected 0001", rows);
    end
    checks++;
    if (key_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: key_valid=%b expected 0", key_valid);
    end
    checks++;
    if (scanning !== 1'b1) begin
      errors++; $display("FAIL reset_scanning: scanning=%b expected 1", scanning);
    end
    checks++;
    if (key_code !== 4'h0) begin
      errors++; $display("FAIL reset_code: key_code=%h expected 0", key_code);
    end
    key_on = 1'b0;
    @(negedge clk); reset = 1'b0; key_ready = 1'b1;
    step(40);
    checks++;
    if (acc.size() !== 0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_spurious: handshakes=%0d valid=%b expected 0/0", acc.size(), key_valid);
    end
    // Reset while the press debounce is in progress.
    key_on = 1'b1; key_ready = 1'b1;
    apply_reset();
    step(14);
    checks++;
    if (scanning !== 1'b0) begin
      errors++; $display("FAIL reset_pre_debounce: scanning=%b expected 0", scanning);
    end
    @(posedge clk); #3; reset = 1'b1; #1;
    checks++;
    if (scanning !== 1'b1 || rows !== 4'b0001) begin
      errors++; $display("FAIL reset_mid_debounce: scanning=%b rows=%b expected 1/0001", scanning, rows);
    end
    key_on = 1'b0;
    @(negedge clk); reset = 1'b0;
    step(40);
    checks++;
    if (acc.size() !== 0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL reset_debounce_discard: handshakes=%0d valid=%b expected 0/0", acc.size(), key_valid);
    end
    $display("test_reset: done, errors=%0d", errors);
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp;
    key_on = 1'b0; key_ready = 1'b1;
    apply_reset();
    checks++;
    if (rows !== 4'b0001) begin
      errors++; $display("FAIL idle_rows_start: rows=%b expected 0001", rows);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp = 4'b0001 << ((k / 5) % 4);
      checks++;
      if (rows !== exp) begin
        errors++; $display("FAIL idle_rows k=%0d: rows=%b expected %b", k, rows, exp);
      end
      checks++;
      if (scanning !== 1'b1) begin
        errors++; $display("FAIL idle_scanning k=%0d: scanning=%b expected 1", k, scanning);
      end
    end
    $display("test_idle_scan: done, errors=%0d", errors);
  endtask

  task automatic test_clean_press();
    logic       exp_v;
    logic       exp_s;
    logic [3:0] exp_r;
    key_row = 2'd1; key_mask = 4'b0100; key_on = 1'b1; key_ready = 1'b1;
    apply_reset();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_v = (k == 19);
      exp_s = (k < 10);
      exp_r = (k < 5) ? 4'b0001 : 4'b0010;
      checks++;
      if (key_valid !== exp_v) begin
        errors++; $display("FAIL press_valid k=%0d: key_valid=%b expected %b", k, key_valid, exp_v);
      end
      checks++;
      if (scanning !== exp_s) begin
        errors++; $display("FAIL press_scanning k=%0d: scanning=%b expected %b", k, scanning, exp_s);
      end
      checks++;
      if (rows !== exp_r) begin
        errors++; $display("FAIL press_rows k=%0d: rows=%b expected %b", k, rows, exp_r);
      end
      if (k == 19) begin
        checks++;
        if (key_code !== 4'h6) begin
          errors++; $display("FAIL press_code: key_code=%h expected 6", key_code);
        end
      end
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b0 || rows !== 4'b0010) begin
        errors++; $display("FAIL press_hold k=%0d: valid=%b rows=%b expected 0/0010", k, key_valid, rows);
      end
    end
    key_on = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp_r = (k <= 10) ? 4'b0010 : 4'b0100;
      checks++;
      if (rows !== exp_r) begin
        errors++; $display("FAIL release_rows k=%0d: rows=%b expected %b", k, rows, exp_r);
      end
    end
    checks++;
    if (acc.size() !== 1 || acc[0] !== 4'h6) begin
      errors++; $display("FAIL press_handshakes: count=%0d expected exactly one key 6", acc.size());
    end
    $display("test_clean_press: done, errors=%0d", errors);
  endtask

  task automatic test_bounce();
    logic [3:0] exp_r;
    key_row = 2'd3; key_mask = 4'b0001; key_on = 1'b0; key_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      key_on = ~key_on;
      step(3);
    end
    key_on = 1'b1;
    step(100);
    checks++;
    if (acc.size() !== 1 || acc[0] !== 4'hE) begin
      errors++; $display("FAIL bounce_key: count=%0d expected exactly one key E", acc.size());
    end
    key_on = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp_r = (k <= 10) ? 4'b1000 : 4'b0001;
      checks++;
      if (rows !== exp_r) begin
        errors++; $display("FAIL bounce_release_rows k=%0d: rows=%b expected %b", k, rows, exp_r);
      end
    end
    step(30);
    checks++;
    if (acc.size() !== 1) begin
      errors++; $display("FAIL bounce_no_repeat: count=%0d expected 1", acc.size());
    end
    $display("test_bounce: done, errors=%0d", errors);
  endtask

  task automatic test_backpressure();
    key_row = 2'd1; key_mask = 4'b0010; key_on = 1'b1; key_ready = 1'b0;
    apply_reset();
    step(30);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h5) begin
      errors++; $display("FAIL bp_first: valid=%b code=%h expected 1/5", key_valid, key_code);
    end
    // Release "5" and press "9" on row 2.
    key_row = 2'd2; key_mask = 4'b0100;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b1 || key_code !== 4'h5) begin
        errors++; $display("FAIL bp_hold k=%0d: valid=%b code=%h expected 1/5", k, key_valid, key_code);
      end
    end
    checks++;
    if (scanning !== 1'b0 || acc.size() !== 0) begin
      errors++; $display("FAIL bp_stall: scanning=%b handshakes=%0d expected 0/0", scanning, acc.size());
    end
    key_ready = 1'b1;
    step(5);
    checks++;
    if (acc.size() !== 2 || acc[0] !== 4'h5 || acc[1] !== 4'h9) begin
      errors++; $display("FAIL bp_order: count=%0d expected keys 5 then 9", acc.size());
    end
    checks++;
    if (key_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drained: key_valid=%b expected 0", key_valid);
    end
    key_on = 1'b0;
    step(20);
    $display("test_backpressure: done, errors=%0d", errors);
  endtask

  task automatic test_ghost();
    int row3_seen;
    row3_seen = 0;
    key_row = 2'd0; key_mask = 4'b0011; key_on = 1'b1; key_ready = 1'b1;
    apply_reset();
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (rows == 4'b1000) row3_seen++;
    end
`ifdef KEYPAD_GHOST_REJECT_EN
    checks++;
    if (acc.size() !== 0) begin
      errors++; $display("FAIL ghost_reject: handshakes=%0d expected 0", acc.size());
    end
    checks++;
    if (row3_seen == 0 || scanning !== 1'b1) begin
      errors++; $display("FAIL ghost_scan: row3 cycles=%0d scanning=%b expected >0/1", row3_seen, scanning);
    end
`else
    checks++;
    if (acc.size() !== 1 || acc[0] !== 4'h1) begin
      errors++; $display("FAIL ghost_lowest: count=%0d expected exactly one key 1", acc.size());
    end
    checks++;
    if (row3_seen !== 0) begin
      errors++; $display("FAIL ghost_hold_row: row3 cycles=%0d expected 0", row3_seen);
    end
`endif
    key_on = 1'b0;
    step(20);
    $display("test_ghost: done, errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_bounce();
    test_backpressure();
    test_ghost();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
